loop_ctrl: RTL and testbench

Parametrised iterative datapath controller: fetch, load, then a counted loop of two compute phases plus a step phase. It drives operand-select, register/memory/accumulator enables and the loop counter. Iteration count is latched internally per run, so no external carry-out is needed. Adds abort, busy, configurable done mode and zero-iteration handling; sits between the top-level start/done handshake and the operand-mux/register datapath.

---
 rtl/loop_ctrl_pkg.sv | 13 +
 rtl/iter_counter.sv | 31 +++
 rtl/loop_ctrl.sv | 103 ++++++++++
 tb/tb_loop_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/loop_ctrl_pkg.sv
// loop_ctrl_pkg: shared state encoding and operand-select constants
package loop_ctrl_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        PH_A  = 3'd3,
        PH_B  = 3'd4,
        STEP  = 3'd5
    } state_t;
    localparam logic OP_DEFAULT  = 1'b1;
    localparam logic OP_FEEDBACK = 1'b0;
endpackage

// File: rtl/iter_counter.sv
// iter_counter: loadable iteration index with latched target and terminal compare
module iter_counter
    import loop_ctrl_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inc,
    input  logic [CNT_W-1:0] target_in,
    output logic [CNT_W-1:0] idx,
    output logic             last,
    output logic             zero
);
    logic [CNT_W-1:0] target;
    // load latches a new target and restarts the index; inc advances it
    always_ff @(posedge clk) begin
        if (rst) begin
            target <= '0;
            idx    <= '0;
        end else if (load) begin
            target <= target_in;
            idx    <= '0;
        end else if (inc) begin
            idx <= idx + 1'b1;
        end
    end
    assign last = idx == target - 1'b1;
    assign zero = target == '0;
endmodule

// File: rtl/loop_ctrl.sv
// loop_ctrl: fetch/load then counted PH_A/PH_B/STEP loop controller
module loop_ctrl
    import loop_ctrl_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int N_SEL     = 4,
    parameter int DONE_HOLD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] iter_count,
    output logic [N_SEL-1:0] op_sel,
    output logic             regs_en,
    output logic             m_en,
    output logic             sel,
    output logic             f_en,
    output logic             cnt_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter_idx
);
    state_t state, next;
    logic   accept, complete, last, zero, done_q;

    assign accept = state == IDLE && start && !abort;
    assign busy   = state != IDLE;
    assign done   = !abort && (complete || (DONE_HOLD != 0 && done_q));

    iter_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .inc       (cnt_en && !last),
        .target_in (iter_count),
        .idx       (iter_idx),
        .last      (last),
        .zero      (zero)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    // sticky completion flag, only visible on done when DONE_HOLD is set
    always_ff @(posedge clk) begin
        if (rst || accept || abort) done_q <= 1'b0;
        else if (complete)          done_q <= 1'b1;
    end

    // next-state and Moore output decode; abort kills enables and completion
    always_comb begin
        next     = state;
        op_sel   = {N_SEL{OP_DEFAULT}};
        regs_en  = 1'b0;
        m_en     = 1'b0;
        sel      = 1'b0;
        f_en     = 1'b0;
        cnt_en   = 1'b0;
        complete = 1'b0;
        case (state)
            IDLE:  next = accept ? FETCH : IDLE;
            FETCH: begin
                m_en = 1'b1;
                next = LOAD;
            end
            LOAD: begin
                regs_en  = 1'b1;
                complete = zero;
                next     = zero ? IDLE : PH_A;
            end
            PH_A: begin
                sel  = 1'b1;
                f_en = 1'b1;
                next = PH_B;
            end
            PH_B: begin
                m_en    = 1'b1;
                f_en    = 1'b1;
                regs_en = 1'b1;
                op_sel  = {N_SEL{OP_FEEDBACK}};
                next    = STEP;
            end
            STEP: begin
                cnt_en   = 1'b1;
                complete = last;
                next     = last ? IDLE : PH_A;
            end
            default: next = IDLE;
        endcase
        if (abort && state != IDLE) begin
            regs_en  = 1'b0;
            m_en     = 1'b0;
            f_en     = 1'b0;
            cnt_en   = 1'b0;
            complete = 1'b0;
            next     = IDLE;
        end
    end
endmodule

// File: tb/tb_loop_ctrl.sv
// tb_loop_ctrl: directed tests for loop_ctrl in pulse and held done modes
module tb_loop_ctrl;
    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic [7:0] iter_count;
    logic [3:0] op_sel, h_op_sel;
    logic       regs_en, m_en, sel, f_en, cnt_en, busy, done;
    logic       h_regs_en, h_m_en, h_sel, h_f_en, h_cnt_en, h_busy, h_done;
    logic [7:0] iter_idx, h_iter_idx;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    loop_ctrl #(.CNT_W(8), .N_SEL(4), .DONE_HOLD(0)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .iter_count(iter_count),
        .op_sel(op_sel), .regs_en(regs_en), .m_en(m_en), .sel(sel), .f_en(f_en),
        .cnt_en(cnt_en), .busy(busy), .done(done), .iter_idx(iter_idx)
    );

    loop_ctrl #(.CNT_W(8), .N_SEL(4), .DONE_HOLD(1)) dut_h (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .iter_count(iter_count),
        .op_sel(h_op_sel), .regs_en(h_regs_en), .m_en(h_m_en), .sel(h_sel), .f_en(h_f_en),
        .cnt_en(h_cnt_en), .busy(h_busy), .done(h_done), .iter_idx(h_iter_idx)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // start a run of n iterations and collect per-cycle statistics until idle
    task automatic run(input logic [7:0] n, output int nb, output int nc, output int nz,
                       output int nsf, output int nd, output int align, output logic [7:0] last_idx);
        iter_count = n;
        start = 1'b1;
        tick();
        start = 1'b0;
        iter_count = ~n;
        nb = 0; nc = 0; nz = 0; nsf = 0; nd = 0; align = 0; last_idx = iter_idx;
        total++;
        if (iter_idx !== 8'd0) begin
            bad++;
            $display("FAIL run_idx_start n=%0d got %0d want 0", n, iter_idx);
        end
        for (int i = 0; i < 1000 && busy; i++) begin
            nb++;
            if (cnt_en) nc++;
            if (op_sel == 4'b0000) nz++;
            if (sel || f_en) nsf++;
            if (done) nd++;
            if (done && (n == 0 ? regs_en : (cnt_en && nc == n))) align++;
            last_idx = iter_idx;
            tick();
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL run_timeout n=%0d busy=%b want 0", n, busy);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; abort = 1'b0; iter_count = 8'd0;
        tick(); tick();
        rst = 1'b0;
        total++;
        if ({op_sel, regs_en, m_en, sel, f_en, cnt_en, busy, done} !== {4'hF, 7'b0}) begin
            bad++;
            $display("FAIL reset_outputs got %b want %b", {op_sel, regs_en, m_en, sel, f_en, cnt_en, busy, done}, {4'hF, 7'b0});
        end
        total++;
        if (iter_idx !== 8'd0) begin
            bad++;
            $display("FAIL reset_idx got %0d want 0", iter_idx);
        end
        iter_count = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        total++;
        if (op_sel !== 4'b0000 || busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_reach_ph_b op_sel=%b busy=%b want 0000 1", op_sel, busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({op_sel, busy, done, h_done} !== {4'hF, 3'b0} || iter_idx !== 8'd0) begin
            bad++;
            $display("FAIL reset_midrun op_sel=%b busy=%b done=%b h_done=%b idx=%0d want 1111 0 0 0 0", op_sel, busy, done, h_done, iter_idx);
        end
    endtask

    task automatic test_count3;
        int nb, nc, nz, nsf, nd, al;
        logic [7:0] li;
        run(8'd3, nb, nc, nz, nsf, nd, al, li);
        total++;
        if (nb !== 11) begin bad++; $display("FAIL n3_busy got %0d want 11", nb); end
        total++;
        if (nc !== 3) begin bad++; $display("FAIL n3_cnt_en got %0d want 3", nc); end
        total++;
        if (nz !== 3) begin bad++; $display("FAIL n3_op_sel_zero got %0d want 3", nz); end
        total++;
        if (nd !== 1 || al !== 1) begin bad++; $display("FAIL n3_done got %0d aligned %0d want 1 1", nd, al); end
        total++;
        if (li !== 8'd2 || iter_idx !== 8'd2) begin bad++; $display("FAIL n3_idx got %0d/%0d want 2", li, iter_idx); end
        total++;
        if (done !== 1'b0 || h_done !== 1'b1) begin bad++; $display("FAIL n3_idle_done got %b hold %b want 0 1", done, h_done); end
    endtask

    task automatic test_zero;
        int nb, nc, nz, nsf, nd, al;
        logic [7:0] li;
        run(8'd0, nb, nc, nz, nsf, nd, al, li);
        total++;
        if (nb !== 2) begin bad++; $display("FAIL n0_busy got %0d want 2", nb); end
        total++;
        if (nc !== 0 || nsf !== 0 || nz !== 0) begin bad++; $display("FAIL n0_loop cnt=%0d selfen=%0d opz=%0d want 0 0 0", nc, nsf, nz); end
        total++;
        if (nd !== 1 || al !== 1) begin bad++; $display("FAIL n0_done got %0d in_load %0d want 1 1", nd, al); end
    endtask

    task automatic test_hold;
        int nb, nc, nz, nsf, nd, al;
        logic [7:0] li;
        run(8'd1, nb, nc, nz, nsf, nd, al, li);
        total++;
        if (nb !== 5 || nd !== 1 || al !== 1) begin bad++; $display("FAIL n1_run busy=%0d done=%0d al=%0d want 5 1 1", nb, nd, al); end
        tick();
        total++;
        if (h_done !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL hold_idle h_done=%b done=%b want 1 0", h_done, done); end
        iter_count = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (h_done !== 1'b0 || h_busy !== 1'b1) begin bad++; $display("FAIL hold_clear h_done=%b busy=%b want 0 1", h_done, h_busy); end
        tick(); tick(); tick(); tick();
        total++;
        if (h_done !== 1'b1 || h_cnt_en !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL hold_step h_done=%b cnt=%b done=%b want 1 1 1", h_done, h_cnt_en, done); end
        tick();
        total++;
        if (h_done !== 1'b1 || done !== 1'b0 || h_busy !== 1'b0) begin bad++; $display("FAIL hold_again h_done=%b done=%b busy=%b want 1 0 0", h_done, done, h_busy); end
    endtask

    task automatic test_abort;
        int nd = 0;
        iter_count = 8'd5; start = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (done || h_done) nd++;
            tick();
        end
        total++;
        if (sel !== 1'b1 || iter_idx !== 8'd1 || busy !== 1'b1) begin bad++; $display("FAIL abort_ph_a2 sel=%b idx=%0d busy=%b want 1 1 1", sel, iter_idx, busy); end
        abort = 1'b1;
        #1;
        total++;
        if ({regs_en, m_en, f_en, cnt_en, done, h_done} !== 6'b0) begin bad++; $display("FAIL abort_enables got %b want 000000", {regs_en, m_en, f_en, cnt_en, done, h_done}); end
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || h_done !== 1'b0) begin bad++; $display("FAIL abort_idle busy=%b done=%b h_done=%b want 0 0 0", busy, done, h_done); end
        tick();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL abort_blocks_start busy=%b want 0", busy); end
        abort = 1'b0; start = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0 || nd !== 0) begin bad++; $display("FAIL abort_after busy=%b dones=%0d want 0 0", busy, nd); end
    endtask

    task automatic test_full;
        int nb, nc, nz, nsf, nd, al;
        logic [7:0] li;
        run(8'hFF, nb, nc, nz, nsf, nd, al, li);
        total++;
        if (nb !== 767) begin bad++; $display("FAIL ff_busy got %0d want 767", nb); end
        total++;
        if (nc !== 255 || nz !== 255) begin bad++; $display("FAIL ff_cnt got %0d opz %0d want 255 255", nc, nz); end
        total++;
        if (li !== 8'd254 || iter_idx !== 8'd254 || h_iter_idx !== 8'd254) begin bad++; $display("FAIL ff_idx got %0d/%0d/%0d want 254", li, iter_idx, h_iter_idx); end
        total++;
        if (nd !== 1 || al !== 1) begin bad++; $display("FAIL ff_done got %0d aligned %0d want 1 1", nd, al); end
    endtask

    initial begin
        test_reset();
        test_count3();
        test_zero();
        test_hold();
        test_abort();
        test_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
